// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Test-pattern pixel source that sits directly upstream of the VGA controller.
//   It converts the controller's raster counters into active-area coordinates
//   and produces one of four patterns: colour bars, checkerboard, gradient or
//   black. An optional white box can be drawn on top and bounces around the
//   active area, moving once per frame.
//
//   Ports:
//     iCLK        pixel clock, shared with the controller
//     iRST_N      synchronous active-low reset
//     iH_Cont     horizontal raster count (10 bits)
//     iV_Cont     vertical raster count (10 bits)
//     iMode       pattern select: 0 bars, 1 checker, 2 gradient, 3 black
//     iMove       1 = box advances at each frame tick
//     iBoxEn      1 = box overlay drawn
//     oRed/oGreen/oBlue  registered pixel colour, one cycle after the counters
//     oFrame      8-bit frame counter, wraps
//     oFrameTick  one-cycle pulse per frame, the cycle after (0, Y_START+V_ACT)
module vga_pattern_gen #(
    parameter int H_SYNC_CYC  = 95,
    parameter int H_SYNC_BACK = 47,
    parameter int H_ACT       = 635,
    parameter int V_SYNC_CYC  = 2,
    parameter int V_SYNC_BACK = 33,
    parameter int V_ACT       = 480,
    parameter int BAR_W       = 80,
    parameter int CHK_BIT     = 5,
    parameter int BOX_SIZE    = 32,
    parameter int STEP        = 4
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [9:0] iH_Cont,
    input  logic [9:0] iV_Cont,
    input  logic [1:0] iMode,
    input  logic       iMove,
    input  logic       iBoxEn,
    output logic [7:0] oRed,
    output logic [7:0] oGreen,
    output logic [7:0] oBlue,
    output logic [7:0] oFrame,
    output logic       oFrameTick
);

    localparam logic [10:0] X_START = 11'(H_SYNC_CYC + H_SYNC_BACK);
    localparam logic [10:0] Y_START = 11'(V_SYNC_CYC + V_SYNC_BACK);
    localparam logic [10:0] X_END   = 11'(H_SYNC_CYC + H_SYNC_BACK + H_ACT);
    localparam logic [10:0] Y_END   = 11'(V_SYNC_CYC + V_SYNC_BACK + V_ACT);
    localparam logic [10:0] H_ACT11 = 11'(H_ACT);
    localparam logic [10:0] V_ACT11 = 11'(V_ACT);
    localparam logic [10:0] BOX11   = 11'(BOX_SIZE);
    localparam logic [10:0] STEP11  = 11'(STEP);

    logic [10:0] h11, v11, x, y;
    logic        active;
    logic        tick_cond;

    logic [1:0]  mode;
    logic [10:0] box_x, box_y;
    logic        dir_x, dir_y;        // 1 = moving towards larger coordinates
    logic [10:0] box_x_nxt, box_y_nxt;
    logic        dir_x_nxt, dir_y_nxt;

    logic [2:0]  bar_idx;
    logic        in_box;
    logic [23:0] pix;

    assign h11       = {1'b0, iH_Cont};
    assign v11       = {1'b0, iV_Cont};
    assign x         = h11 - X_START;
    assign y         = v11 - Y_START;
    assign active    = (h11 >= X_START) && (h11 < X_END) &&
                       (v11 >= Y_START) && (v11 < Y_END);
    assign tick_cond = (iH_Cont == 10'd0) && (v11 == Y_END);

    // Bar index = floor(x / BAR_W) clamped to 7, done as threshold compares
    // so no divider is needed.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= 11'(i * BAR_W)) bar_idx = 3'(i);
        end
    end

    assign in_box = (x >= box_x) && (x < box_x + BOX11) &&
                    (y >= box_y) && (y < box_y + BOX11);

    always_comb begin
        pix = 24'h000000;
        if (active) begin
            case (mode)
                2'd0: begin
                    case (bar_idx)
                        3'd0:    pix = 24'hFFFFFF;
                        3'd1:    pix = 24'hFFFF00;
                        3'd2:    pix = 24'h00FFFF;
                        3'd3:    pix = 24'h00FF00;
                        3'd4:    pix = 24'hFF00FF;
                        3'd5:    pix = 24'hFF0000;
                        3'd6:    pix = 24'h0000FF;
                        default: pix = 24'h000000;
                    endcase
                end
                2'd1:    pix = (x[CHK_BIT] ^ y[CHK_BIT]) ? 24'hFFFFFF : 24'h000000;
                2'd2:    pix = {x[7:0], y[7:0], oFrame};
                default: pix = 24'h000000;
            endcase
            if (iBoxEn && in_box) pix = 24'hFFFFFF;
        end
    end

    // Bounce: clamp against the edge and reverse once the next step would
    // reach or cross it.
    always_comb begin
        box_x_nxt = box_x;
        dir_x_nxt = dir_x;
        if (dir_x) begin
            if (box_x + STEP11 + BOX11 >= H_ACT11) begin
                box_x_nxt = H_ACT11 - BOX11;
                dir_x_nxt = 1'b0;
            end else begin
                box_x_nxt = box_x + STEP11;
            end
        end else begin
            if (box_x <= STEP11) begin
                box_x_nxt = 11'd0;
                dir_x_nxt = 1'b1;
            end else begin
                box_x_nxt = box_x - STEP11;
            end
        end
    end

    always_comb begin
        box_y_nxt = box_y;
        dir_y_nxt = dir_y;
        if (dir_y) begin
            if (box_y + STEP11 + BOX11 >= V_ACT11) begin
                box_y_nxt = V_ACT11 - BOX11;
                dir_y_nxt = 1'b0;
            end else begin
                box_y_nxt = box_y + STEP11;
            end
        end else begin
            if (box_y <= STEP11) begin
                box_y_nxt = 11'd0;
                dir_y_nxt = 1'b1;
            end else begin
                box_y_nxt = box_y - STEP11;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oRed       <= 8'd0;
            oGreen     <= 8'd0;
            oBlue      <= 8'd0;
            oFrame     <= 8'd0;
            oFrameTick <= 1'b0;
            mode       <= 2'd0;
            box_x      <= 11'd0;
            box_y      <= 11'd0;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
        end else begin
            {oRed, oGreen, oBlue} <= pix;
            oFrameTick            <= tick_cond;
            if (tick_cond) begin
                oFrame <= oFrame + 8'd1;
                mode   <= iMode;
                if (iMove) begin
                    box_x <= box_x_nxt;
                    box_y <= box_y_nxt;
                    dir_x <= dir_x_nxt;
                    dir_y <= dir_y_nxt;
                end
            end
        end
    end

endmodule
